muldiv_seq_32: RTL

MULDIV_SEQ_32 -- requirements
Module: muldiv_seq_32

---
 rtl/muldiv_seq_32.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq_32.sv
// muldiv_seq_32: sequential signed 32x32 multiplier / divider.
// Each operation takes 34 busy cycles, one result bit per cycle. Divide-by-zero
// is the exception: it skips the iterations and finishes one cycle after PREP.
//
// Ports
//   in_clk        single clock, rising edge
//   in_rst_n      asynchronous active-low reset
//   in_start      operation request, sampled only in IDLE
//   in_opcode     4'b1000 signed MUL, 4'b1001 signed DIV; any other code is ignored
//   in_a, in_b    operands, two's complement
//   out_busy      high in PREP, ITER and FIX
//   out_done      one-cycle completion pulse (DONE state)
//   out_hi        MUL: product[63:32]   DIV: remainder
//   out_lo        MUL: product[31:0]    DIV: quotient
//   out_div_zero  set by a DIV with in_b == 0; cleared when the next start is accepted
//
// State table
//   state | meaning
//   IDLE  | waiting for in_start with a valid opcode; operands are captured on accept
//   PREP  | latch signs, form magnitudes, clear counter and accumulator (div-by-zero -> DONE)
//   ITER  | 32 unsigned shift-add / restoring-divide steps, counter 0..31
//   FIX   | apply signs and write out_hi / out_lo
//   DONE  | out_done pulse, then return to IDLE
module muldiv_seq_32 (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_start,
    input  logic [3:0]  in_opcode,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_busy,
    output logic        out_done,
    output logic [31:0] out_hi,
    output logic [31:0] out_lo,
    output logic        out_div_zero
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;

    logic [2:0]  state;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic [4:0]  cnt;
    // MUL: op_x = |a|, {acc_hi, acc_lo} = running product with the multiplier
    //      shifting out of acc_lo.
    // DIV: op_x = |b|, acc_hi = partial remainder, and acc_lo shifts dividend
    //      bits out while quotient bits shift in.
    logic [31:0] op_x;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] prod;
    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;

    // The magnitude of 0x80000000 stays 0x80000000, which is exactly 2^31 when read as unsigned.
    assign mag_a = a_reg[31] ? (~a_reg + 32'd1) : a_reg;
    assign mag_b = b_reg[31] ? (~b_reg + 32'd1) : b_reg;

    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_x} : 33'd0);

    // The partial remainder is always below the divisor, so the shifted value fits in 33 bits.
    // When the subtraction is taken, its true result is below 2^32.
    assign div_shift = {acc_hi, acc_lo[31]};
    assign div_ge    = (div_shift >= {1'b0, op_x});
    assign div_sub   = div_shift[31:0] - op_x;

    assign prod   = {acc_hi, acc_lo};
    assign prod_s = neg_res ? (~prod + 64'd1) : prod;
    assign quo_s  = neg_res ? (~acc_lo + 32'd1) : acc_lo;
    assign rem_s  = neg_rem ? (~acc_hi + 32'd1) : acc_hi;

    assign out_busy = (state == S_PREP) || (state == S_ITER) || (state == S_FIX);
    assign out_done = (state == S_DONE);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state        <= S_IDLE;
            a_reg        <= 32'd0;
            b_reg        <= 32'd0;
            is_div       <= 1'b0;
            neg_res      <= 1'b0;
            neg_rem      <= 1'b0;
            cnt          <= 5'd0;
            op_x         <= 32'd0;
            acc_hi       <= 32'd0;
            acc_lo       <= 32'd0;
            out_hi       <= 32'd0;
            out_lo       <= 32'd0;
            out_div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_start && (in_opcode == OP_MUL || in_opcode == OP_DIV)) begin
                        a_reg        <= in_a;
                        b_reg        <= in_b;
                        is_div       <= (in_opcode == OP_DIV);
                        out_div_zero <= 1'b0;
                        state        <= S_PREP;
                    end
                end
                S_PREP: begin
                    neg_res <= a_reg[31] ^ b_reg[31];
                    neg_rem <= a_reg[31];
                    cnt     <= 5'd0;
                    acc_hi  <= 32'd0;
                    if (is_div) begin
                        op_x   <= mag_b;
                        acc_lo <= mag_a;
                    end else begin
                        op_x   <= mag_a;
                        acc_lo <= mag_b;
                    end
                    if (is_div && (b_reg == 32'd0)) begin
                        out_lo       <= 32'hFFFF_FFFF;
                        out_hi       <= a_reg;
                        out_div_zero <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (is_div) begin
                        if (div_ge) begin
                            acc_hi <= div_sub;
                            acc_lo <= {acc_lo[30:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[31:0];
                            acc_lo <= {acc_lo[30:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[32:1];
                        acc_lo <= {mul_sum[0], acc_lo[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        out_lo <= quo_s;
                        out_hi <= rem_s;
                    end else begin
                        out_lo <= prod_s[31:0];
                        out_hi <= prod_s[63:32];
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
